// File: rtl/tpsram_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for tpsram_fifo_ctrl.
// ALMOST_FULL/ALMOST_EMPTY exist only with FIFO_ALMOST_FLAGS_EN.
interface tpsram_fifo_ctrl_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] S_DATA;
  logic              S_VALID;
  logic              S_READY;
  logic [DATA_W-1:0] M_DATA;
  logic              M_VALID;
  logic              M_READY;
  logic [DATA_W-1:0] W_DATA;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic [ADDR_W-1:0] R_ADDR;
  logic              R_EN;
  logic [DATA_W-1:0] R_DATA;
  logic [ADDR_W:0]   COUNT;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;
`endif

  modport master (
    output S_DATA, S_VALID, M_READY, R_DATA,
    input  S_READY, M_DATA, M_VALID,
    input  W_DATA, W_ADDR, W_EN,
    input  R_ADDR, R_EN, COUNT
`ifdef FIFO_ALMOST_FLAGS_EN
    , input ALMOST_FULL, ALMOST_EMPTY
`endif
  );

  modport slave (
    input  S_DATA, S_VALID, M_READY, R_DATA,
    output S_READY, M_DATA, M_VALID,
    output W_DATA, W_ADDR, W_EN,
    output R_ADDR, R_EN, COUNT
`ifdef FIFO_ALMOST_FLAGS_EN
    , output ALMOST_FULL, ALMOST_EMPTY
`endif
  );
endinterface

// File: rtl/tpsram_fifo_ctrl.sv
// FIFO controller over a 1-cycle-latency two-port SRAM with a 2-entry prefetch buffer.
// Optional FIFO_ALMOST_FLAGS_EN adds registered ALMOST_FULL/ALMOST_EMPTY.
module tpsram_fifo_ctrl #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6
`ifdef FIFO_ALMOST_FLAGS_EN
  , parameter int AF_THRESH = 60
  , parameter int AE_THRESH = 4
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  tpsram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic       s_ready;
  logic       m_valid;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic [2:0] occ_net;
  logic [1:0] bc;

  assign s_ready = ~RST & (ram_cnt_q < DEPTH);
  assign m_valid = (buf_cnt_q != 2'd0);

  always_comb begin
    push      = bus.S_VALID & s_ready;
    pop       = m_valid & bus.M_READY;
    occ       = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    occ_net   = occ - {2'b00, pop};
    // Never let buffered + in-flight words exceed the 2 buffer slots
    issue     = (ram_cnt_q != '0) && (occ_net < 3'd2);
    wptr_d    = wptr_q + {{(ADDR_W-1){1'b0}}, push};
    rptr_d    = rptr_q + {{(ADDR_W-1){1'b0}}, issue};
    ram_cnt_d = ram_cnt_q
              + {{ADDR_W{1'b0}}, push}
              - {{ADDR_W{1'b0}}, issue};
    inflight_d = issue;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    bc     = buf_cnt_q;
    if (pop) begin
      buf0_d = buf1_q;
      bc     = bc - 2'd1;
    end
    if (inflight_q) begin
      if (bc == 2'd0) buf0_d = bus.R_DATA;
      else            buf1_d = bus.R_DATA;
      bc = bc + 2'd1;
    end
    buf_cnt_d = bc;
    count_d   = ram_cnt_d
              + {{(ADDR_W-1){1'b0}}, buf_cnt_d}
              + {{ADDR_W{1'b0}}, inflight_d};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.M_VALID = m_valid;
  assign bus.M_DATA  = buf0_q;
  assign bus.W_EN    = push;
  assign bus.W_ADDR  = wptr_q;
  assign bus.W_DATA  = bus.S_DATA;
  assign bus.R_EN    = issue;
  assign bus.R_ADDR  = rptr_q;
  assign bus.COUNT   = count_q;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_W:0] AF_T = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_T = AE_THRESH[ADDR_W:0];

  logic af_q;
  logic ae_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= AF_T);
      ae_q <= (count_d <= AE_T);
    end
  end

  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
`endif

endmodule

// File: doc/tpsram_fifo_ctrl.md
Name: tpsram_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns both ports of the 64x20 two-port SRAM (PF_TPSRAM) in the counter_and_fifo design.
- Accepts a valid/ready write stream and converts it into SRAM write cycles.
- Prefetches SRAM reads into a 2-entry output buffer, hiding the 1-cycle SRAM read latency.
- Presents a valid/ready read stream to the downstream consumer.

Parameters:
- DATA_W, 20, data width; matches the SRAM W_DATA/R_DATA width.
- ADDR_W, 6, SRAM address width; RAM depth = 2**ADDR_W = 64.
- AF_THRESH, 60, almost-full threshold on COUNT; used only with FIFO_ALMOST_FLAGS_EN.
- AE_THRESH, 4, almost-empty threshold on COUNT; used only with FIFO_ALMOST_FLAGS_EN.

Ports:
- CLK  in  1  single clock for the controller and the SRAM.
- RST  in  1  asynchronous, active-high reset.
- S_DATA  in  DATA_W  write-side data.
- S_VALID  in  1  write-side valid.
- S_READY  out  1  write-side ready.
- M_DATA  out  DATA_W  read-side data (head of FIFO).
- M_VALID  out  1  read-side valid.
- M_READY  in  1  read-side ready.
- W_DATA  out  DATA_W  to SRAM W_DATA.
- W_ADDR  out  ADDR_W  to SRAM W_ADDR.
- W_EN  out  1  to SRAM W_EN.
- R_ADDR  out  ADDR_W  to SRAM R_ADDR.
- R_EN  out  1  to SRAM R_EN.
- R_DATA  in  DATA_W  from SRAM R_DATA; valid the cycle after the edge that sampled R_EN=1.
- COUNT  out  ADDR_W+1  total stored words (RAM + output buffer), 0..66.

Behaviour:
- Clock/reset: one clock, CLK; reset RST is asynchronous and active-high. Reset clears wptr, rptr, ram_cnt, inflight, buffer occupancy and COUNT. Outputs during and after reset: S_READY=1 once RST deasserts (0 while asserted), M_VALID=0, M_DATA=0, W_EN=0, R_EN=0, W_ADDR=0, R_ADDR=0, COUNT=0.
- Reset mid-operation: stored contents discarded; any in-flight read is dropped, and R_DATA from the cycle after reset is ignored.
- Push: push = S_VALID & S_READY. S_READY = (ram_cnt < 2**ADDR_W). S_READY is registered-state only; no combinational path from M_READY or S_VALID.
- Write port: on push, W_EN=1, W_ADDR=wptr, W_DATA=S_DATA, all combinational. wptr increments at the edge and wraps 63->0 naturally via ADDR_W bits.
- Read issue: R_EN=1 when ram_cnt>0 and (buf_cnt + inflight - pop) < 2, with R_ADDR=rptr. On issue, rptr increments (wraps 63->0), ram_cnt decrements, and inflight is set for the next cycle.
- Read capture: the cycle after issue, R_DATA is written into the output buffer at the edge.
- Ordering: a word written at edge N is never read before edge N+1; read eligibility uses registered ram_cnt only. No RAM bypass path; every word passes through the SRAM.
- Output buffer: 2-entry in-order skid buffer; M_DATA = head entry, M_VALID = (buf_cnt>0). pop = M_VALID & M_READY. M_DATA holds stable while M_VALID=1 and M_READY=0.
- Latency: word accepted at edge 0 -> R_EN in cycle 1 -> R_DATA in cycle 2 -> M_VALID=1 in cycle 3 (FIFO previously empty).
- Throughput: 1 push and 1 pop per cycle sustained.
- Simultaneous push and pop: both honoured; ram_cnt and COUNT are updated by net delta.
- Full: ram_cnt=64 -> S_READY=0; total capacity = 66 words (64 RAM + 2 buffer).
- Empty: COUNT=0 -> M_VALID=0, R_EN=0.
- COUNT = ram_cnt + buf_cnt + inflight, registered, updated each edge.
- Illegal use: a push while S_READY=0 is ignored; no state change.

Optional Feature:
- FIFO_ALMOST_FLAGS_EN defined: adds registered outputs ALMOST_FULL (COUNT >= AF_THRESH) and ALMOST_EMPTY (COUNT <= AE_THRESH). Both update on the same edge as COUNT; reset values ALMOST_FULL=0, ALMOST_EMPTY=1.
- FIFO_ALMOST_FLAGS_EN undefined: those ports and their logic are absent, and AF_THRESH/AE_THRESH are unused.

Test Plan:
- Reset, then push 0x00001 at edge 0 with M_READY=0 -> R_EN=1, R_ADDR=0 in cycle 1; M_VALID=1, M_DATA=0x00001 from cycle 3; COUNT=1.
- Push 0..65 back-to-back with M_READY=0 -> S_READY drops after 66 accepts (COUNT=66, ram_cnt=64); 67th S_VALID not accepted; then drain with M_READY=1 -> outputs 0..65 in order, one per cycle.
- Continuous push and pop of 200 incrementing words -> no gaps after initial latency; W_ADDR and R_ADDR wrap 63->0 and back; output sequence exact.
- Random M_READY stalls (50%) during streaming -> M_DATA stable while stalled; no loss or duplication.
- Assert RST for 1 cycle with COUNT=30 and a read in flight -> next cycle M_VALID=0, COUNT=0, pointers 0; subsequent push 0xABCDE emerges first.
- With FIFO_ALMOST_FLAGS_EN: fill to 60 -> ALMOST_FULL=1; drain to 4 -> ALMOST_EMPTY=1; at 5 -> ALMOST_EMPTY=0.
